// File: rtl/k2_pkg.sv
// k2_pkg: shared types and field positions for the K2 fetch/decode block.
// The optional retired-instruction counter in k2_fetch_decode is enabled by
// defining K2_PERF_CNT_EN; nothing in this package depends on it.
package k2_pkg;

    // Opcode field positions inside an instruction byte
    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 6;
    localparam int DEST_MSB = 5;
    localparam int DEST_LSB = 4;
    localparam int COND_MSB = 5;
    localparam int COND_LSB = 4;
    localparam int SUB_BIT  = 3;

    // Instruction class carried in instr[7:6]
    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_LDI  = 2'b01,
        CLS_JMP  = 2'b10,
        CLS_HALT = 2'b11
    } opclass_e;

    // Jump condition carried in instr[5:4]
    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_C      = 2'b01,
        COND_Z      = 2'b10,
        COND_NZ     = 2'b11
    } cond_e;

    // Sequencer states
    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        FETCH_OP = 3'd2,
        EXEC     = 3'd3,
        HALT     = 3'd4
    } state_e;

    // Evaluates a jump condition against the flags presented this cycle
    function automatic logic branch_taken(input cond_e cond, input logic c, input logic z);
        logic taken;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_C:      taken = c;
            COND_Z:      taken = z;
            COND_NZ:     taken = ~z;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/k2_pc.sv
// k2_pc: program counter with load, increment and asynchronous reset.
// Load wins over increment; the increment wraps naturally at 2^bits-1.
module k2_pc
    import k2_pkg::*;
#(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [bits-1:0] load_val_i,
    input  logic            inc_i,
    output logic [bits-1:0] pc_o
);

    localparam logic [bits-1:0] PC_ONE = {{(bits-1){1'b0}}, 1'b1};

    logic [bits-1:0] pc_q;
    logic [bits-1:0] pc_d;

    // Next PC: jump target, sequential increment, or hold
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // PC register, cleared to address 0 on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/k2_fetch_decode.sv
// k2_fetch_decode: multi-cycle fetch/decode sequencer for the K2 core.
// Fetches one instruction byte, optionally a second operand byte, then
// spends one EXEC cycle driving register-file / ALU controls or a jump.
// Define K2_PERF_CNT_EN to add retired_o, a saturating count of EXEC cycles.
module k2_fetch_decode
    import k2_pkg::*;
#(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [bits-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [bits-1:0] imem_data,
    input  logic            c_i,
    input  logic            z_i,
    output logic            alu_s_o,
    output logic            rf_we_o,
    output logic [1:0]      rf_sel_o,
    output logic            imm_sel_o,
    output logic [bits-1:0] imm_o,
    output logic [bits-1:0] pc_o,
    output logic            halted_o
`ifdef K2_PERF_CNT_EN
    ,
    output logic [15:0]     retired_o
`endif
);

    state_e          state_q;
    state_e          state_d;
    logic [bits-1:0] instr_q;
    logic [bits-1:0] instr_d;
    logic [bits-1:0] operand_q;
    logic [bits-1:0] operand_d;

    logic            pc_load;
    logic            pc_inc;
    logic [bits-1:0] pc;

    opclass_e        op_class;
    cond_e           jmp_cond;
    logic [1:0]      dest;
    logic            sub_sel;
    logic            instr_unused;

    // Instruction fields, decoded from the latched instruction byte
    assign op_class = opclass_e'(instr_q[OPC_MSB:OPC_LSB]);
    assign jmp_cond = cond_e'(instr_q[COND_MSB:COND_LSB]);
    assign dest     = instr_q[DEST_MSB:DEST_LSB];
    assign sub_sel  = instr_q[SUB_BIT];

    // The low instruction bits carry no meaning; fold them so they are consumed
    assign instr_unused = ^instr_q;

    k2_pc #(
        .bits (bits)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (operand_q),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    assign imem_addr = pc;
    assign pc_o      = pc;

    // Sequencer next-state, instruction/operand capture and control outputs
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        operand_d = operand_q;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        imem_req  = 1'b0;
        rf_we_o   = 1'b0;
        alu_s_o   = 1'b0;
        rf_sel_o  = 2'b00;
        imm_sel_o = 1'b0;
        imm_o     = '0;
        halted_o  = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_data;
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                case (op_class)
                    CLS_ALU:  state_d = EXEC;
                    CLS_LDI:  state_d = FETCH_OP;
                    CLS_JMP:  state_d = FETCH_OP;
                    CLS_HALT: state_d = HALT;
                    default:  state_d = HALT;
                endcase
            end

            FETCH_OP: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    operand_d = imem_data;
                    pc_inc    = 1'b1;
                    state_d   = EXEC;
                end
            end

            EXEC: begin
                state_d = FETCH;
                case (op_class)
                    CLS_ALU: begin
                        rf_we_o  = 1'b1;
                        alu_s_o  = sub_sel;
                        rf_sel_o = dest;
                    end
                    CLS_LDI: begin
                        rf_we_o   = 1'b1;
                        imm_sel_o = 1'b1;
                        imm_o     = operand_q;
                        rf_sel_o  = dest;
                    end
                    CLS_JMP: begin
                        pc_load = branch_taken(jmp_cond, c_i, z_i);
                    end
                    default: begin
                    end
                endcase
            end

            HALT: begin
                halted_o = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Sequencer state and instruction/operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            operand_q <= operand_d;
        end
    end

`ifdef K2_PERF_CNT_EN
    logic [15:0] retired_q;
    logic [15:0] retired_d;

    // Count every completed EXEC cycle, holding at the all-ones ceiling
    always_comb begin
        retired_d = retired_q;
        if ((state_q == EXEC) && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 16'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_o = retired_q;
`endif

endmodule

// File: tb/tb_k2_fetch_decode.sv
// tb_k2_fetch_decode: directed bench for k2_fetch_decode with a zero-wait
// byte memory model and a scoreboard of expected register-file writes.
module tb_k2_fetch_decode;

    typedef struct packed {
        logic       alu_s;
        logic [1:0] sel;
        logic       imm_sel;
        logic [7:0] imm;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic       c_i;
    logic       z_i;
    logic       alu_s_o;
    logic       rf_we_o;
    logic [1:0] rf_sel_o;
    logic       imm_sel_o;
    logic [7:0] imm_o;
    logic [7:0] pc_o;
    logic       halted_o;
`ifdef K2_PERF_CNT_EN
    logic [15:0] retired_o;
`endif

    logic [7:0] mem [256];
    logic       mem_ready;
    wr_t        exp_q [$];
    wr_t        mon_e;
    int         vectors;
    int         miscompares;

    logic [7:0] jmp_instr [7] = '{8'hA0, 8'hA0, 8'h90, 8'h90, 8'hB0, 8'hB0, 8'h80};
    logic [7:0] jmp_tgt   [7] = '{8'h10, 8'h10, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55};
    logic       jmp_c     [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
    logic       jmp_z     [7] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    logic [7:0] jmp_pc    [7] = '{8'h10, 8'h02, 8'h33, 8'h02, 8'h44, 8'h02, 8'h55};

    k2_fetch_decode #(
        .bits (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .c_i        (c_i),
        .z_i        (z_i),
        .alu_s_o    (alu_s_o),
        .rf_we_o    (rf_we_o),
        .rf_sel_o   (rf_sel_o),
        .imm_sel_o  (imm_sel_o),
        .imm_o      (imm_o),
        .pc_o       (pc_o),
        .halted_o   (halted_o)
`ifdef K2_PERF_CNT_EN
        ,
        .retired_o  (retired_o)
`endif
    );

    // Zero-wait memory unless the bench deliberately withholds mem_ready
    assign imem_valid = imem_req & mem_ready;
    assign imem_data  = mem[imem_addr];

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, landing on a falling edge
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Fill memory with HALT so stray fetches stop the core
    task automatic fillMem();
        for (int a = 0; a < 256; a++) mem[a] = 8'hC0;
    endtask

    // Reset pulse released on a falling edge; the next rising edge is cycle 1
    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && rf_we_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_we", rf_we_o, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_alu_s", alu_s_o, mon_e.alu_s);
                checkOutput("sb_rf_sel", rf_sel_o, mon_e.sel);
                checkOutput("sb_imm_sel", imm_sel_o, mon_e.imm_sel);
                checkOutput("sb_imm", imm_o, mon_e.imm);
            end
        end
    end

    // Directed sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        c_i         = 1'b0;
        z_i         = 1'b0;
        mem_ready   = 1'b1;

        // ALU sub into r0, then HALT
        fillMem();
        mem[0] = 8'h08;
        exp_q.push_back('{alu_s: 1'b1, sel: 2'd0, imm_sel: 1'b0, imm: 8'h00});
        resetDut();
        checkOutput("rst_imem_req", imem_req, 1);
        checkOutput("rst_imem_addr", imem_addr, 0);
        checkOutput("rst_pc", pc_o, 0);
        checkOutput("rst_halted", halted_o, 0);
        checkOutput("rst_rf_we", rf_we_o, 0);
        checkOutput("rst_alu_s", alu_s_o, 0);
        checkOutput("rst_rf_sel", rf_sel_o, 0);
        checkOutput("rst_imm_sel", imm_sel_o, 0);
        checkOutput("rst_imm", imm_o, 0);
        applyStimulus(1);
        checkOutput("alu_c2_we", rf_we_o, 0);
        checkOutput("alu_c2_pc", pc_o, 1);
        checkOutput("alu_c2_req", imem_req, 0);
        applyStimulus(1);
        checkOutput("alu_c3_we", rf_we_o, 1);
        checkOutput("alu_c3_pc", pc_o, 1);
        applyStimulus(1);
        checkOutput("alu_next_req", imem_req, 1);
        checkOutput("alu_next_addr", imem_addr, 1);
        checkOutput("alu_next_we", rf_we_o, 0);
        applyStimulus(3);
        checkOutput("halt_halted", halted_o, 1);
        checkOutput("halt_req", imem_req, 0);
        checkOutput("halt_pc", pc_o, 2);
        applyStimulus(5);
        checkOutput("halt_hold_halted", halted_o, 1);
        checkOutput("halt_hold_req", imem_req, 0);
        checkOutput("alu_sb_drain", exp_q.size(), 0);

        // LDI r1, 0x3C
        fillMem();
        mem[0] = 8'h50;
        mem[1] = 8'h3C;
        exp_q.push_back('{alu_s: 1'b0, sel: 2'd1, imm_sel: 1'b1, imm: 8'h3C});
        resetDut();
        applyStimulus(2);
        checkOutput("ldi_fop_req", imem_req, 1);
        checkOutput("ldi_fop_addr", imem_addr, 1);
        checkOutput("ldi_fop_we", rf_we_o, 0);
        applyStimulus(1);
        checkOutput("ldi_exec_we", rf_we_o, 1);
        checkOutput("ldi_exec_pc", pc_o, 2);
        applyStimulus(1);
        checkOutput("ldi_after_we", rf_we_o, 0);
        checkOutput("ldi_sb_drain", exp_q.size(), 0);

        // Conditional and unconditional jumps, taken and not taken
        for (int i = 0; i < 7; i++) begin
            fillMem();
            mem[0] = jmp_instr[i];
            mem[1] = jmp_tgt[i];
            c_i    = jmp_c[i];
            z_i    = jmp_z[i];
            resetDut();
            applyStimulus(3);
            checkOutput($sformatf("jmp%0d_exec_we", i), rf_we_o, 0);
            applyStimulus(1);
            checkOutput($sformatf("jmp%0d_pc", i), pc_o, jmp_pc[i]);
            checkOutput($sformatf("jmp%0d_addr", i), imem_addr, jmp_pc[i]);
        end
        c_i = 1'b0;
        z_i = 1'b0;

        // Memory withholds valid for five cycles in FETCH
        fillMem();
        mem[0]    = 8'h08;
        mem_ready = 1'b0;
        exp_q.push_back('{alu_s: 1'b1, sel: 2'd0, imm_sel: 1'b0, imm: 8'h00});
        resetDut();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1);
            checkOutput($sformatf("wait%0d_req", k), imem_req, 1);
            checkOutput($sformatf("wait%0d_addr", k), imem_addr, 0);
            checkOutput($sformatf("wait%0d_pc", k), pc_o, 0);
            checkOutput($sformatf("wait%0d_we", k), rf_we_o, 0);
        end
        mem_ready = 1'b1;
        applyStimulus(1);
        checkOutput("wait_decode_pc", pc_o, 1);
        applyStimulus(1);
        checkOutput("wait_exec_we", rf_we_o, 1);
        applyStimulus(1);
        checkOutput("wait_sb_drain", exp_q.size(), 0);

        // Jump to 0xFF, LDI there fetches its operand from 0x00, then 0xFF halts
        fillMem();
        mem[8'h00] = 8'h80;
        mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'h64;
        exp_q.push_back('{alu_s: 1'b0, sel: 2'd2, imm_sel: 1'b1, imm: 8'h80});
        resetDut();
        applyStimulus(4);
        checkOutput("wrap_jmp_pc", pc_o, 8'hFF);
        applyStimulus(1);
        checkOutput("wrap_decode_pc", pc_o, 8'h00);
        applyStimulus(1);
        checkOutput("wrap_fop_addr", imem_addr, 8'h00);
        checkOutput("wrap_fop_req", imem_req, 1);
        applyStimulus(1);
        checkOutput("wrap_exec_we", rf_we_o, 1);
        checkOutput("wrap_exec_pc", pc_o, 8'h01);
        applyStimulus(3);
        checkOutput("wrap_halted", halted_o, 1);
        applyStimulus(10);
        checkOutput("wrap_halt_hold", halted_o, 1);
        checkOutput("wrap_halt_req", imem_req, 0);
        checkOutput("wrap_halt_pc", pc_o, 2);
        checkOutput("wrap_sb_drain", exp_q.size(), 0);

        // Reset during FETCH_OP abandons the LDI; the rerun then completes
        fillMem();
        mem[0] = 8'h50;
        mem[1] = 8'h3C;
        resetDut();
        applyStimulus(2);
        checkOutput("rfop_addr_pre", imem_addr, 1);
        rst = 1'b1;
        #1;
        checkOutput("rfop_we", rf_we_o, 0);
        checkOutput("rfop_pc", pc_o, 0);
        applyStimulus(1);
        rst = 1'b0;
        #1;
        checkOutput("rfop_req", imem_req, 1);
        checkOutput("rfop_addr", imem_addr, 0);
        checkOutput("rfop_halted", halted_o, 0);
        exp_q.push_back('{alu_s: 1'b0, sel: 2'd1, imm_sel: 1'b1, imm: 8'h3C});
        applyStimulus(3);
        checkOutput("rfop_rerun_we", rf_we_o, 1);
        applyStimulus(1);
        checkOutput("rfop_sb_drain", exp_q.size(), 0);

        // Reset landing just after entry to EXEC suppresses the write strobe
        resetDut();
        applyStimulus(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rexec_we", rf_we_o, 0);
        checkOutput("rexec_pc", pc_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rexec_req", imem_req, 1);
        checkOutput("rexec_addr", imem_addr, 0);
        checkOutput("rexec_sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/k2_fetch_decode.md
K2_FETCH_DECODE -- requirements
Module: k2_fetch_decode

Interface
REQ-001 SHALL have parameter: bits, 8, width of PC, instruction, operand and immediate.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory request, held until imem_valid.
REQ-005 SHALL have port: imem_addr  output  bits  fetch address, equal to PC, stable while imem_req=1.
REQ-006 SHALL have port: imem_valid  input  1  imem_data valid; sampled only while imem_req=1.
REQ-007 SHALL have port: imem_data  input  bits  fetched byte.
REQ-008 SHALL have port: c_i, z_i  input  1 each  registered carry/zero flags from the ALU flag stage.
REQ-009 SHALL have port: alu_s_o  output  1  ALU select, 0=add, 1=sub.
REQ-010 SHALL have port: rf_we_o  output  1  register-file write strobe, one-cycle pulse.
REQ-011 SHALL have port: rf_sel_o  output  2  destination register index.
REQ-012 SHALL have port: imm_sel_o  output  1  1 = write imm_o, 0 = write ALU result.
REQ-013 SHALL have port: imm_o  output  bits  immediate operand.
REQ-014 SHALL have port: pc_o  output  bits  current PC.
REQ-015 SHALL have port: halted_o  output  1  high in HALT state.

Function
REQ-016 SHALL decode instr[7:6]: 00 ALU (s=instr[3]), 01 LDI, 10 JMP (cond=instr[5:4]: 00 always, 01 C=1, 10 Z=1, 11 Z=0), 11 HALT; dest=instr[5:4] for ALU/LDI.
REQ-017 SHALL implement FSM states FETCH, DECODE, FETCH_OP, EXEC, HALT.
REQ-018 FETCH SHALL assert imem_req; on imem_valid latch instr, PC<=PC+1, go DECODE; otherwise stay.
REQ-019 DECODE SHALL go to EXEC for ALU, FETCH_OP for LDI/JMP, HALT for HALT.
REQ-020 FETCH_OP SHALL assert imem_req; on imem_valid latch operand, PC<=PC+1, go EXEC.
REQ-021 EXEC SHALL last exactly one cycle then go to FETCH.
REQ-022 EXEC for ALU SHALL pulse rf_we_o with alu_s_o=s, imm_sel_o=0, rf_sel_o=dest.
REQ-023 EXEC for LDI SHALL pulse rf_we_o with imm_sel_o=1, imm_o=operand.
REQ-024 EXEC for JMP SHALL sample c_i/z_i in that cycle; if taken, PC<=operand; else PC unchanged; rf_we_o=0.
REQ-025 HALT SHALL be terminal: imem_req=0, rf_we_o=0, halted_o=1 until reset.
REQ-026 PC SHALL wrap 2^bits-1 -> 0, including during FETCH_OP.
REQ-027 Latency: ALU instruction 3 cycles, LDI/JMP 4 cycles, each with zero-wait memory.
REQ-028 rf_we_o SHALL be 0 in every state except EXEC.

Reset
REQ-029 On rst: state=FETCH, PC=0, instr/operand=0, all outputs 0 except imem_req=1 and imem_addr=0 after release.
REQ-030 rst asserted mid-fetch or mid-EXEC SHALL abandon the instruction, suppressing any rf_we_o pulse.

Configuration
REQ-031 With K2_PERF_CNT_EN defined, the block SHALL add output retired_o [15:0] counting completed EXEC cycles, saturating at 0xFFFF and reset to 0.
REQ-032 Without K2_PERF_CNT_EN, retired_o and its counter SHALL not exist.

Structure
REQ-033 Package k2_pkg SHALL hold opclass enum, branch-condition enum, FSM state enum and opcode field position constants.
REQ-034 PC SHALL live in sub-module k2_pc (load, increment, async reset).

Verification
REQ-035 Stream 0x08 (ALU sub, dest 0), zero-wait -> rf_we_o pulse at cycle 3, alu_s_o=1, rf_sel_o=0, PC=1.
REQ-036 Stream 0x50,0x3C (LDI r1,0x3C) -> rf_we_o pulse, imm_sel_o=1, rf_sel_o=1, imm_o=0x3C, PC=2.
REQ-037 JZ 0xA0,0x10 with z_i=1 -> PC=0x10; same with z_i=0 -> PC=2.
REQ-038 imem_valid held low 5 cycles in FETCH -> imem_req and imem_addr stable, no state change.
REQ-039 PC=0xFF with LDI -> operand fetched at 0x00, PC ends 0x01; 0xC0 -> halted_o=1, imem_req=0 forever.
REQ-040 rst pulse during FETCH_OP -> no rf_we_o, PC=0, FETCH from address 0.
